// File: rtl/energy_monitor_pkg.sv
// Shared types and widths for the energy-monitor sequencer.
package energy_monitor_pkg;

  localparam int DRAIN_W = 4;
  localparam int STALL_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ACCUM,
    DRAIN,
    OUT
  } state_e;

endpackage

// File: rtl/energy_monitor_seq_if.sv
// Stream, accumulator-control and status signals of the energy-monitor sequencer.
interface energy_monitor_seq_if
  import energy_monitor_pkg::*;
#(
  parameter int COUNTER_BITWIDTH = 8
) ();

  logic                        config_valid_i;
  logic                        config_ready_o;
  logic [COUNTER_BITWIDTH-1:0] config_counter_i;
  logic                        spin_valid_i;
  logic                        spin_ready_o;
  logic                        weight_valid_i;
  logic                        weight_ready_o;
  logic                        acc_clear_o;
  logic                        acc_en_o;
  logic                        energy_valid_o;
  logic                        energy_ready_i;
  logic [COUNTER_BITWIDTH-1:0] step_cnt_o;
  logic                        busy_o;
  logic [STALL_W-1:0]          stall_cnt_o;

  // The sequencer is the slave of every inbound stream.
  modport slave (
    input  config_valid_i, config_counter_i, spin_valid_i, weight_valid_i, energy_ready_i,
    output config_ready_o, spin_ready_o, weight_ready_o, acc_clear_o, acc_en_o,
           energy_valid_o, step_cnt_o, busy_o, stall_cnt_o
  );

  modport master (
    output config_valid_i, config_counter_i, spin_valid_i, weight_valid_i, energy_ready_i,
    input  config_ready_o, spin_ready_o, weight_ready_o, acc_clear_o, acc_en_o,
           energy_valid_o, step_cnt_o, busy_o, stall_cnt_o
  );

endinterface

// File: rtl/em_step_cnt.sv
// Step counter with its N register; flags the step that reaches N (or N==0 on clear).
module em_step_cnt #(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic [CW-1:0] n_i,
  input  logic          clear_i,
  input  logic          step_i,
  output logic          finish_o,
  output logic [CW-1:0] count_o
);

  logic [CW-1:0] n_q;
  logic [CW-1:0] cnt_q;
  logic [CW:0]   count_plus;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) n_q <= n_i;
      if (clear_i)     cnt_q <= '0;
      else if (step_i) cnt_q <= cnt_q + CW'(1);
    end
  end

  // One extra bit keeps the compare exact even when the counter is at its top.
  assign count_plus = {1'b0, cnt_q} + (CW + 1)'(step_i);
  assign finish_o   = clear_i ? (n_q == '0) : (count_plus == {1'b0, n_q});
  assign count_o    = cnt_q;

endmodule

// File: rtl/energy_monitor_seq.sv
// Energy-monitor sequencer: config -> spin -> N weight rows -> drain -> result.
// Optional stall counter enabled by defining ENERGY_MONITOR_SEQ_STALL_CNT_EN.
module energy_monitor_seq
  import energy_monitor_pkg::*;
#(
  parameter int COUNTER_BITWIDTH = 8,
  parameter int PIPES            = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  energy_monitor_seq_if.slave  bus
);

  localparam int                DRAIN_LAST_INT = (PIPES > 0) ? PIPES - 1 : 0;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST    = DRAIN_W'(DRAIN_LAST_INT);
  localparam state_e            POST_ACCUM     = (PIPES == 0) ? OUT : DRAIN;

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 active;
  logic                 cfg_hs, spin_hs, w_hs, out_hs;
  logic                 finish;

  // Readies are held low during reset so every output reads 0 while rst_ni is low.
  assign active             = en_i && rst_ni;
  assign bus.config_ready_o = active && (state_q == IDLE || state_q == READY);
  assign bus.spin_ready_o   = active && (state_q == READY) && !bus.config_valid_i;
  assign bus.weight_ready_o = active && (state_q == ACCUM);
  assign bus.energy_valid_o = (state_q == OUT);
  assign bus.busy_o         = (state_q == ACCUM) || (state_q == DRAIN) || (state_q == OUT);

  assign cfg_hs  = bus.config_valid_i && bus.config_ready_o;
  assign spin_hs = bus.spin_valid_i   && bus.spin_ready_o;
  assign w_hs    = bus.weight_valid_i && bus.weight_ready_o;
  assign out_hs  = bus.energy_valid_o && bus.energy_ready_i;

  assign bus.acc_clear_o = spin_hs;
  assign bus.acc_en_o    = w_hs;

  em_step_cnt #(
    .CW (COUNTER_BITWIDTH)
  ) u_step_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (cfg_hs),
    .n_i      (bus.config_counter_i),
    .clear_i  (spin_hs),
    .step_i   (w_hs),
    .finish_o (finish),
    .count_o  (bus.step_cnt_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: defaults first so every path assigns state_d/drain_d; no latches.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE:  if (cfg_hs) state_d = READY;
      READY: if (spin_hs) state_d = finish ? POST_ACCUM : ACCUM;
      ACCUM: if (w_hs && finish) state_d = POST_ACCUM;
      DRAIN: begin
        // Timer only advances while enabled; it is always 0 on entry.
        if (en_i) begin
          if (drain_q == DRAIN_LAST) begin
            drain_d = '0;
            state_d = OUT;
          end else begin
            drain_d = drain_q + DRAIN_W'(1);
          end
        end
      end
      OUT:     if (out_hs) state_d = READY;
      default: state_d = IDLE;
    endcase
  end

`ifdef ENERGY_MONITOR_SEQ_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (spin_hs) begin
      stall_d = '0;
    end else if (state_q == ACCUM && en_i && !bus.weight_valid_i && stall_q != '1) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign bus.stall_cnt_o = stall_q;
`else
  assign bus.stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_energy_monitor_seq.sv
// Directed self-checking bench for energy_monitor_seq (COUNTER_BITWIDTH=8, PIPES=1).
module tb_energy_monitor_seq;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic en_i   = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  energy_monitor_seq_if #(.COUNTER_BITWIDTH(8)) emif ();

  energy_monitor_seq #(
    .COUNTER_BITWIDTH (8),
    .PIPES            (1)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (en_i),
    .bus    (emif)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Let combinational outputs settle after input changes before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic do_config(input logic [7:0] n);
    emif.config_valid_i   = 1'b1;
    emif.config_counter_i = n;
    settle();
    check("cfg_ready", emif.config_ready_o, 1'b1);
    tick();
    emif.config_valid_i = 1'b0;
  endtask

  task automatic do_spin();
    emif.spin_valid_i = 1'b1;
    settle();
    check("spin_clear", emif.acc_clear_o, 1'b1);
    tick();
    emif.spin_valid_i = 1'b0;
  endtask

  int accepted;
  int valid_cycles;

  initial begin
    emif.config_valid_i   = 1'b0;
    emif.config_counter_i = '0;
    emif.spin_valid_i     = 1'b0;
    emif.weight_valid_i   = 1'b0;
    emif.energy_ready_i   = 1'b0;

    // Reset state
    settle();
    check("rst_cfg_ready", emif.config_ready_o, 1'b0);
    check("rst_valid", emif.energy_valid_o, 1'b0);
    check("rst_busy", emif.busy_o, 1'b0);
    check("rst_step", emif.step_cnt_o, 8'd0);
    check("rst_stall", emif.stall_cnt_o, 16'd0);
    tick();
    rst_ni = 1'b1;
    settle();
    check("idle_cfg_ready", emif.config_ready_o, 1'b1);
    check("idle_spin_ready", emif.spin_ready_o, 1'b0);

    // N=4, four back-to-back weights
    do_config(8'd4);
    settle();
    check("ready_spin_ready", emif.spin_ready_o, 1'b1);
    check("ready_busy", emif.busy_o, 1'b0);
    do_spin();
    settle();
    check("accum_w_ready", emif.weight_ready_o, 1'b1);
    check("accum_clear_low", emif.acc_clear_o, 1'b0);
    check("accum_busy", emif.busy_o, 1'b1);
    check("accum_step0", emif.step_cnt_o, 8'd0);
    for (int i = 0; i < 4; i++) begin
      emif.weight_valid_i = 1'b1;
      settle();
      check("t1_acc_en", emif.acc_en_o, 1'b1);
      tick();
      check("t1_step", emif.step_cnt_o, 32'(i + 1));
    end
    settle();
    check("t1_drain_w_ready", emif.weight_ready_o, 1'b0);
    check("t1_drain_acc_en", emif.acc_en_o, 1'b0);
    check("t1_drain_valid", emif.energy_valid_o, 1'b0);
    emif.weight_valid_i = 1'b0;
    tick();
    check("t1_out_valid", emif.energy_valid_o, 1'b1);
    check("t1_out_step", emif.step_cnt_o, 8'd4);
    emif.energy_ready_i = 1'b1;
    tick();
    emif.energy_ready_i = 1'b0;
    settle();
    check("t1_back_valid", emif.energy_valid_o, 1'b0);
    check("t1_back_spin_ready", emif.spin_ready_o, 1'b1);
    check("t1_hold_step", emif.step_cnt_o, 8'd4);

    // N=0: spin goes straight to drain, result 2 cycles after spin
    do_config(8'd0);
    do_spin();
    settle();
    check("n0_w_ready", emif.weight_ready_o, 1'b0);
    check("n0_valid_early", emif.energy_valid_o, 1'b0);
    check("n0_step", emif.step_cnt_o, 8'd0);
    tick();
    check("n0_valid", emif.energy_valid_o, 1'b1);
    check("n0_w_ready_out", emif.weight_ready_o, 1'b0);
    emif.energy_ready_i = 1'b1;
    tick();
    emif.energy_ready_i = 1'b0;

    // N=3, weight_valid held, result back-pressured 5 cycles
    do_config(8'd3);
    do_spin();
    emif.weight_valid_i = 1'b1;
    accepted     = 0;
    valid_cycles = 0;
    for (int i = 0; i < 9; i++) begin
      settle();
      accepted     += int'(emif.acc_en_o);
      valid_cycles += int'(emif.energy_valid_o);
      tick();
    end
    check("n3_accepted", 32'(accepted), 32'd3);
    check("n3_valid_cycles", 32'(valid_cycles), 32'd5);
    check("n3_step", emif.step_cnt_o, 8'd3);
    emif.energy_ready_i = 1'b1;
    settle();
    check("n3_still_valid", emif.energy_valid_o, 1'b1);
    tick();
    emif.energy_ready_i = 1'b0;
    emif.weight_valid_i = 1'b0;
    settle();
    check("n3_ready_state", emif.spin_ready_o, 1'b1);
    check("n3_no_valid", emif.energy_valid_o, 1'b0);

    // Config and spin together: config wins, spin one cycle later
    emif.config_valid_i   = 1'b1;
    emif.config_counter_i = 8'd2;
    emif.spin_valid_i     = 1'b1;
    settle();
    check("pri_cfg_ready", emif.config_ready_o, 1'b1);
    check("pri_spin_ready", emif.spin_ready_o, 1'b0);
    check("pri_no_clear", emif.acc_clear_o, 1'b0);
    tick();
    emif.config_valid_i = 1'b0;
    settle();
    check("pri_spin_ready_next", emif.spin_ready_o, 1'b1);
    check("pri_clear_next", emif.acc_clear_o, 1'b1);
    tick();
    emif.spin_valid_i     = 1'b0;
    emif.config_valid_i   = 1'b1;
    emif.config_counter_i = 8'd9;
    emif.weight_valid_i   = 1'b1;
    settle();
    check("busy_cfg_ready", emif.config_ready_o, 1'b0);
    tick();
    tick();
    settle();
    check("busy_n_kept_step", emif.step_cnt_o, 8'd2);
    check("busy_n_kept_drain", emif.weight_ready_o, 1'b0);
    emif.config_valid_i = 1'b0;
    emif.weight_valid_i = 1'b0;
    tick();
    check("pri_out_valid", emif.energy_valid_o, 1'b1);
    emif.energy_ready_i = 1'b1;
    tick();
    emif.energy_ready_i = 1'b0;

    // en_i low mid-ACCUM freezes at step 2; en_i low in OUT still honours handshake
    do_config(8'd4);
    do_spin();
    emif.weight_valid_i = 1'b1;
    tick();
    tick();
    check("en_step2", emif.step_cnt_o, 8'd2);
    en_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("en_low_w_ready", emif.weight_ready_o, 1'b0);
      check("en_low_acc_en", emif.acc_en_o, 1'b0);
      tick();
      check("en_low_step", emif.step_cnt_o, 8'd2);
    end
    en_i = 1'b1;
    tick();
    tick();
    check("en_resume_step", emif.step_cnt_o, 8'd4);
    emif.weight_valid_i = 1'b0;
    en_i = 1'b0;
    tick();
    settle();
    check("en_low_drain_frozen", emif.energy_valid_o, 1'b0);
    en_i = 1'b1;
    tick();
    check("en_out_valid", emif.energy_valid_o, 1'b1);
    en_i = 1'b0;
    tick();
    check("en_low_valid_held", emif.energy_valid_o, 1'b1);
    emif.energy_ready_i = 1'b1;
    tick();
    emif.energy_ready_i = 1'b0;
    settle();
    check("en_low_out_hs", emif.energy_valid_o, 1'b0);
    check("en_low_spin_ready", emif.spin_ready_o, 1'b0);
    en_i = 1'b1;
    settle();
    check("en_high_spin_ready", emif.spin_ready_o, 1'b1);

    // Reset mid-DRAIN
    do_config(8'd1);
    do_spin();
    emif.weight_valid_i = 1'b1;
    tick();
    emif.weight_valid_i = 1'b0;
    settle();
    check("pre_rst_busy", emif.busy_o, 1'b1);
    rst_ni = 1'b0;
    settle();
    check("mid_rst_valid", emif.energy_valid_o, 1'b0);
    check("mid_rst_busy", emif.busy_o, 1'b0);
    check("mid_rst_cfg_ready", emif.config_ready_o, 1'b0);
    check("mid_rst_step", emif.step_cnt_o, 8'd0);
    tick();
    rst_ni = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      valid_cycles += int'(emif.energy_valid_o) + int'(emif.acc_clear_o);
      tick();
    end
    check("post_rst_quiet", 32'(valid_cycles), 32'd0);
    settle();
    check("post_rst_idle_cfg", emif.config_ready_o, 1'b1);
    check("post_rst_idle_spin", emif.spin_ready_o, 1'b0);

    // Stall counter: 7 starved ACCUM cycles, cleared by next spin
    do_config(8'd2);
    do_spin();
    for (int i = 0; i < 7; i++) tick();
`ifdef ENERGY_MONITOR_SEQ_STALL_CNT_EN
    check("stall_7", emif.stall_cnt_o, 16'd7);
`else
    check("stall_off", emif.stall_cnt_o, 16'd0);
`endif
    emif.weight_valid_i = 1'b1;
    tick();
    tick();
    emif.weight_valid_i = 1'b0;
    tick();
    emif.energy_ready_i = 1'b1;
    tick();
    emif.energy_ready_i = 1'b0;
    do_spin();
    check("stall_cleared", emif.stall_cnt_o, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
